// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined FP multiplier.
// Field extractors, bias, class codes, flag indices, canonical qNaN.
package fp_pkg;

  typedef enum logic [2:0] {
    ZERO, NORM, INF, QNAN, SNAN
  } fp_cls_e;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_NV = 3;

  function automatic logic f_sign(
    logic [63:0] x, int exp_w, int man_w);
    logic [63:0] t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [63:0] f_exp(
    logic [63:0] x, int exp_w, int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] f_man(
    logic [63:0] x, int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic int f_bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] f_qnan(
    int exp_w, int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w)
      | (64'd1 << (man_w - 1));
  endfunction

  // Subnormals classify as ZERO (denormals-are-zero).
  function automatic fp_cls_e f_class(
    logic [63:0] x, int exp_w, int man_w);
    logic [63:0] e, m, t;
    e = f_exp(x, exp_w, man_w);
    m = f_man(x, man_w);
    t = m >> (man_w - 1);
    if (e == 64'd0) return ZERO;
    if (e != (64'd1 << exp_w) - 64'd1) return NORM;
    if (m == 64'd0) return INF;
    return t[0] ? QNAN : SNAN;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Valid/ready operand and result channels of fp_mul_pipe.
// master drives operands/out_ready; slave is the multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_flags
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even plus exponent range check (combinational).
// In: kept man, G, S, signed exp. Out: man_r, exp_r, ovf/unf/inx.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0]        man,
  input  logic                    g,
  input  logic                    s,
  input  logic signed [EXP_W+1:0] exp,
  output logic [MAN_W-1:0]        man_r,
  output logic [EXP_W-1:0]        exp_r,
  output logic                    ovf,
  output logic                    unf,
  output logic                    inx
);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << EXP_W) - 1);

  logic                 up;
  logic                 carry;
  logic [MAN_W-1:0]     man_i;
  logic signed [EW-1:0] e_f;

  assign up    = g & (man[0] | s);
  // all-ones mantissa wraps to zero; carry bumps the exponent
  assign carry = up & (&man);
  assign man_i = man + MAN_W'(up);
  assign e_f   = exp + $signed(EW'(carry));

  always_comb begin
    ovf   = !e_f[EW-1] && (e_f >= EMAX);
    unf   = e_f[EW-1] || (e_f == '0);
    inx   = g | s | ovf | unf;
    man_r = man_i;
    exp_r = e_f[EXP_W-1:0];
    if (ovf) begin
      man_r = '0;
      exp_r = '1;
    end else if (unf) begin
      man_r = '0;
      exp_r = '0;
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier, RNE, DAZ/FTZ, exception flags.
// Ports: clk, rst_n, bus (fp_mul_pipe_if.slave).
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS =
    EW'(f_bias(EXP_W));
  localparam logic [W-1:0] QNAN_W =
    W'(f_qnan(EXP_W, MAN_W));

  logic adv;
  assign adv = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // rank 0: captured operands
  logic             v0;
  logic [W-1:0]     a0, b0;
  logic [TAG_W-1:0] tag0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; a0 <= '0; b0 <= '0; tag0 <= '0;
    end else if (adv) begin
      v0   <= bus.in_valid;
      a0   <= bus.in_a;
      b0   <= bus.in_b;
      tag0 <= bus.in_tag;
    end
  end

  // S1: classify, multiply, provisional exponent
  fp_cls_e              cls_a, cls_b;
  logic [EXP_W-1:0]     ea, eb;
  logic [P-1:0]         sig_a, sig_b;
  logic signed [EW-1:0] exp_s1;
  logic [2*P-1:0]       prod_s1;

  assign cls_a  = f_class(64'(a0), EXP_W, MAN_W);
  assign cls_b  = f_class(64'(b0), EXP_W, MAN_W);
  assign ea     = EXP_W'(f_exp(64'(a0), EXP_W, MAN_W));
  assign eb     = EXP_W'(f_exp(64'(b0), EXP_W, MAN_W));
  assign sig_a  = {1'b1, MAN_W'(f_man(64'(a0), MAN_W))};
  assign sig_b  = {1'b1, MAN_W'(f_man(64'(b0), MAN_W))};
  assign exp_s1 = $signed({2'b00, ea})
                + $signed({2'b00, eb}) - BIAS;
  assign prod_s1 = (2*P)'(sig_a) * (2*P)'(sig_b);

  logic                 v1, sgn1;
  logic [TAG_W-1:0]     tag1;
  fp_cls_e              cls_a1, cls_b1;
  logic signed [EW-1:0] exp1;
  logic [2*P-1:0]       prod1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sgn1 <= 1'b0; tag1 <= '0;
      cls_a1 <= ZERO; cls_b1 <= ZERO;
      exp1 <= '0; prod1 <= '0;
    end else if (adv) begin
      v1     <= v0;
      tag1   <= tag0;
      sgn1   <= f_sign(64'(a0), EXP_W, MAN_W)
              ^ f_sign(64'(b0), EXP_W, MAN_W);
      cls_a1 <= cls_a;
      cls_b1 <= cls_b;
      exp1   <= exp_s1;
      prod1  <= prod_s1;
    end
  end

  // S2: normalise, G/S, special select
  logic [2*P-2:0]       pn;
  logic signed [EW-1:0] exp_s2;
  logic                 nan_x, inf_x, zero_x, snan_x;
  logic                 spec_s2, nv_s2;
  logic [W-1:0]         spy_s2;

  assign pn = prod1[2*P-1] ? prod1[2*P-2:0]
                           : {prod1[2*P-3:0], 1'b0};
  assign exp_s2 = exp1 + $signed(EW'(prod1[2*P-1]));

  always_comb begin
    snan_x  = (cls_a1 == SNAN) | (cls_b1 == SNAN);
    nan_x   = snan_x | (cls_a1 == QNAN) | (cls_b1 == QNAN);
    inf_x   = (cls_a1 == INF) | (cls_b1 == INF);
    zero_x  = (cls_a1 == ZERO) | (cls_b1 == ZERO);
    spec_s2 = 1'b0;
    nv_s2   = 1'b0;
    spy_s2  = '0;
    if (nan_x || (inf_x && zero_x)) begin
      spec_s2 = 1'b1;
      spy_s2  = QNAN_W;
      nv_s2   = snan_x | (inf_x & zero_x);
    end else if (inf_x) begin
      spec_s2 = 1'b1;
      spy_s2  = {sgn1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_x) begin
      spec_s2 = 1'b1;
      spy_s2  = {sgn1, {(W-1){1'b0}}};
    end
  end

  logic                 v2, sgn2, spec2, nv2, g2, s2;
  logic [TAG_W-1:0]     tag2;
  logic [W-1:0]         spy2;
  logic [MAN_W-1:0]     man2;
  logic signed [EW-1:0] exp2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; sgn2 <= 1'b0; spec2 <= 1'b0;
      nv2 <= 1'b0; g2 <= 1'b0; s2 <= 1'b0;
      tag2 <= '0; spy2 <= '0; man2 <= '0; exp2 <= '0;
    end else if (adv) begin
      v2    <= v1;
      tag2  <= tag1;
      sgn2  <= sgn1;
      spec2 <= spec_s2;
      nv2   <= nv_s2;
      spy2  <= spy_s2;
      man2  <= pn[2*P-2:P];
      g2    <= pn[P-1];
      s2    <= |pn[P-2:0];
      exp2  <= exp_s2;
    end
  end

  // S3: round, range check, output register
  logic [MAN_W-1:0] man_r;
  logic [EXP_W-1:0] exp_r;
  logic             ovf, unf, inx;
  logic [W-1:0]     y_s3;
  logic [3:0]       fl_s3;

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .man   (man2),
    .g     (g2),
    .s     (s2),
    .exp   (exp2),
    .man_r (man_r),
    .exp_r (exp_r),
    .ovf   (ovf),
    .unf   (unf),
    .inx   (inx)
  );

  always_comb begin
    y_s3  = {sgn2, exp_r, man_r};
    fl_s3 = '0;
    if (spec2) begin
      y_s3 = spy2;
      fl_s3[FLG_NV] = nv2;
    end else begin
      fl_s3[FLG_OF] = ovf;
      fl_s3[FLG_UF] = unf;
      fl_s3[FLG_NX] = inx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_y     <= '0;
      bus.out_tag   <= '0;
      bus.out_flags <= '0;
    end else if (adv) begin
      bus.out_valid <= v2;
      bus.out_y     <= v2 ? y_s3 : '0;
      bus.out_tag   <= v2 ? tag2 : '0;
      bus.out_flags <= v2 ? fl_s3 : '0;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (single precision).
// Scenario tasks run in sequence from one initial block.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] tag,
                        input logic [31:0] ey,
                        input logic [3:0] ef);
    int cyc;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 10);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d want 3", name, cyc);
    end
    checks++;
    if (bus.out_y !== ey) begin
      errors++;
      $display("FAIL %s y: got %h want %h", name, bus.out_y, ey);
    end
    checks++;
    if (bus.out_flags !== ef) begin
      errors++;
      $display("FAIL %s flags: got %b want %b",
               name, bus.out_flags, ef);
    end
    checks++;
    if (bus.out_tag !== tag) begin
      errors++;
      $display("FAIL %s tag: got %h want %h",
               name, bus.out_tag, tag);
    end
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_y !== 32'h0 ||
        bus.out_tag !== 4'h0 || bus.out_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_out: got v=%b y=%h t=%h f=%b want 0",
               bus.out_valid, bus.out_y, bus.out_tag,
               bus.out_flags);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arith;
    run_op("exact", 32'h3FC00000, 32'h40000000, 4'h1,
           32'h40400000, 4'b0000);
    run_op("tie_even", 32'h3F800001, 32'h3FC00000, 4'h2,
           32'h3FC00002, 4'b0001);
    run_op("sticky", 32'h3F800001, 32'h3F800001, 4'h3,
           32'h3F800002, 4'b0001);
    run_op("overflow", 32'h7F000000, 32'h7F000000, 4'h4,
           32'h7F800000, 4'b0101);
    run_op("underflow", 32'h00800000, 32'h3F000000, 4'h5,
           32'h00000000, 4'b0011);
  endtask

  task automatic test_special;
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 4'h6,
           32'h7FC00000, 4'b1000);
    run_op("snan", 32'h7FA00000, 32'h3F800000, 4'h7,
           32'h7FC00000, 4'b1000);
    run_op("neg_inf", 32'hFF800000, 32'h40000000, 4'h8,
           32'hFF800000, 4'b0000);
    run_op("qnan", 32'h7FC00001, 32'h3F800000, 4'h9,
           32'h7FC00000, 4'b0000);
    run_op("neg_zero", 32'h80000000, 32'h40000000, 4'hA,
           32'h80000000, 4'b0000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] bv [6];
    logic [31:0] ev [6];
    logic [31:0] hold_y;
    logic [3:0]  hold_t;
    logic held, saw_block, fire_in, fire_out;
    int sent, got, cyc, extra;
    bv = '{32'h3F800000, 32'h40000000, 32'h40400000,
           32'h40800000, 32'h40A00000, 32'h40C00000};
    ev = '{32'h40000000, 32'h40800000, 32'h40C00000,
           32'h41000000, 32'h41200000, 32'h41400000};
    sent = 0; got = 0; cyc = 0;
    held = 1'b0; saw_block = 1'b0;
    hold_y = '0; hold_t = '0;
    while (got < 6 && cyc < 60) begin
      bus.in_valid = (sent < 6);
      bus.in_a = 32'h40000000;
      bus.in_b = bv[sent < 6 ? sent : 0];
      bus.in_tag = 4'(sent);
      bus.out_ready = (cyc >= 9);
      #1;
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (bus.out_valid && !bus.out_ready) begin
        if (held) begin
          checks++;
          if (bus.out_y !== hold_y || bus.out_tag !== hold_t) begin
            errors++;
            $display("FAIL stall_stable: got %h/%h want %h/%h",
                     bus.out_y, bus.out_tag, hold_y, hold_t);
          end
        end
        held = 1'b1;
        hold_y = bus.out_y;
        hold_t = bus.out_tag;
      end
      if (fire_out) begin
        checks++;
        if (bus.out_tag !== 4'(got) || bus.out_y !== ev[got]) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h/%h want %h/%h",
                   got, bus.out_tag, bus.out_y, 4'(got), ev[got]);
        end
        got++;
        held = 1'b0;
      end
      if (fire_in) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 6", got);
    end
    checks++;
    if (saw_block !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready_drop: got %b want 1", saw_block);
    end
    extra = 0;
    repeat (6) begin
      if (bus.out_valid === 1'b1) extra++;
      tick;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_dup: got %0d extra want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 32'h40000000;
      bus.in_b = 32'h40400000;
      bus.in_tag = 4'(7 + i);
      tick;
    end
    bus.in_valid = 1'b0;
    tick;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_inflight: got %b want 1",
               bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_y !== 32'h0 ||
        bus.out_tag !== 4'h0 || bus.out_flags !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: got v=%b y=%h t=%h f=%b want 0",
               bus.out_valid, bus.out_y, bus.out_tag,
               bus.out_flags);
    end
    tick;
    tick;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      if (bus.out_valid === 1'b1) seen++;
      tick;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_ghost: got %0d want 0", seen);
    end
    run_op("post_reset", 32'h40000000, 32'h40400000, 4'hC,
           32'h40C00000, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_arith;
    test_special;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE 754 binary floating-point multiplier with valid/ready handshaking on both sides. It computes correct round-to-nearest-even products and handles zero, infinity, NaN and overflow/underflow with exception flags. Input and output subnormals are flushed to zero. It sits between operand-issue logic and a result consumer in the FP datapath. The default parameters give single precision. A tag travels alongside each operation so out-of-band context stays matched to its result.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W
- TAG_W, 4, width of the sideband tag carried with each operation
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts the pair on this edge when in_valid is high
- in_a, in_b  in  W  operands: sign at W-1, exponent at W-2:MAN_W, mantissa at MAN_W-1:0
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_y  out  W  product
- out_tag  out  TAG_W  tag of this product
- out_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Sign = sign_a XOR sign_b, except for NaN results.
- Classification, with exp field e and mantissa field m:
  - zero: e=0 (subnormals are treated as zero, DAZ)
  - inf: e=all-ones and m=0
  - NaN: e=all-ones and m≠0
  - sNaN: NaN with m[MAN_W-1]=0
- Special results, in priority order:
  - Either input is NaN, or the operation is inf×zero: result is the canonical qNaN (sign 0, e all-ones, m = 100…0). invalid=1 if either input is an sNaN or the operation is inf×zero.
  - Either input is inf: result is signed inf.
  - Either input is zero: result is signed zero.
  - No flags are raised for the inf and zero cases.
- Finite path:
  - Significands are P = MAN_W+1 bits wide, with the hidden 1 restored.
  - Product is 2P bits. If bit 2P-1 is 0, shift left 1 and set nshift=0; otherwise nshift=1.
- Rounding (RNE): take the kept mantissa from bits 2P-2:P. Then:
  - G = bit P-1
  - S = OR of bits P-2:0 (everything below G)
  - L = bit P
  - Round up when G & (L | S).
  - inexact = G | S.
  - A rounding carry-out (kept mantissa all ones) sets mantissa to 0 and increments the exponent.
- Exponent: signed, EXP_W+2 bits wide, computed as e_a + e_b − bias + nshift + round_carry, where bias = 2^(EXP_W−1)−1.
  - Exponent ≥ all-ones: result is signed inf; overflow=1, inexact=1.
  - Exponent ≤ 0: result is signed zero (FTZ); underflow=1, inexact=1.
- Flags are valid only while out_valid=1 and belong to that result only. They are not sticky.

## Timing
- Three-stage pipeline:
  - S1: classify, 2P-bit multiply, provisional exponent
  - S2: normalise, compute G/S/L, special-case select
  - S3: round, exponent fix-up, overflow/underflow, output register
- Global advance signal: adv = !out_valid | out_ready. in_ready = adv, combinational.
- Latency: a pair accepted on edge k appears with out_valid=1 after edge k+3, given adv stays high. Throughput is 1 per cycle.
- While adv=0 every stage holds. out_y, out_tag and out_flags stay stable while out_valid=1 and out_ready=0.
- Bubbles propagate as stage valid=0. Every stage shifts when adv=1, whether or not it holds valid data.
- Simultaneous accept and output: a pair accepted on the same edge that the output drains is legal, with no lost or duplicated beat.
- Reset, including mid-operation: all stage valids clear immediately. Outputs then read out_valid=0, out_y=0, out_tag=0 and out_flags=0. The first accept after rst_n deasserts is allowed on the first clock edge.
- Results leave in the same order their operands were accepted.

## Structure
- Package fp_pkg holds:
  - the field-extract functions (sign, exp, man) parametrised by EXP_W and MAN_W
  - the bias function
  - class encodings (ZERO, NORM, INF, QNAN, SNAN)
  - the flag-bit index constants
  - the canonical qNaN constant function
- Sub-module fp_round_rne (combinational):
  - inputs: kept mantissa, G, S and signed exponent
  - outputs: rounded mantissa, final exponent and overflow/underflow/inexact
  - it is instantiated in S3.

## Test plan
- Exact product: 0x3FC00000 × 0x40000000 → 0x40400000, flags 0000, out_valid exactly 3 cycles after accept.
- RNE tie rounding up to even: 0x3F800001 × 0x3FC00000 → 0x3FC00002 with inexact=1. Also 0x3F800001 × 0x3F800001 → 0x3F800002 with inexact=1.
- Overflow/underflow: 0x7F000000 × 0x7F000000 → 0x7F800000, flags 0101 (overflow, inexact). 0x00800000 × 0x3F000000 → 0x00000000, flags 0011 (underflow, inexact).
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1
  - 0x7FA00000 (sNaN) × 0x3F800000 → 0x7FC00000, invalid=1
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0000
- Backpressure: stream 6 back-to-back pairs with tags 0–5 while out_ready is held low for 5 cycles. in_ready must drop. Results appear in tag order 0–5 with none lost or duplicated, and outputs stay stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight. out_valid drops immediately and none of the 3 results ever appears. A new pair accepted after reset returns normally.
